// File: rtl/sample_decimator_if.sv
// Sample strobe/data bundle between the codec side and the decimator,
// plus the decimated strobe/sample pair headed for the display.
interface sample_decimator_if;
  logic        new_sample_in;
  logic [15:0] sample_in;
  logic [2:0]  log2_factor;
  logic        mode;
  logic        freeze;
  logic        new_sample_out;
  logic [15:0] sample_out;

  modport master (
    output new_sample_in, sample_in, log2_factor, mode, freeze,
    input  new_sample_out, sample_out
  );

  modport slave (
    input  new_sample_in, sample_in, log2_factor, mode, freeze,
    output new_sample_out, sample_out
  );
endinterface

// File: rtl/sample_decimator.sv
// Power-of-two rate reduction by boxcar average or subsampling, with freeze.
// Factor and mode are latched at group boundaries so a group is never cut short.
module sample_decimator #(
  parameter int unsigned MAX_LOG2 = 7
) (
  input logic             clk,
  input logic             reset,
  sample_decimator_if.slave bus
);
  localparam int unsigned AW = 16 + MAX_LOG2;
  localparam int unsigned CW = 7;

  logic [CW-1:0]        cnt;
  logic signed [AW-1:0] acc;
  logic [2:0]           lf;
  logic                 lm;
  logic                 new_sample_out_q;
  logic [15:0]          sample_out_q;

  logic                 accept_c;
  logic                 group_end_c;
  logic [2:0]           lf_sat_c;
  logic [CW-1:0]        last_cnt_c;
  logic signed [AW-1:0] sum_c;
  logic signed [AW-1:0] avg_c;

  // Acceptance, group-end detection and the arithmetic-shift average.
  always_comb begin
    accept_c    = bus.new_sample_in & ~bus.freeze;
    lf_sat_c    = (32'(bus.log2_factor) > MAX_LOG2) ? 3'(MAX_LOG2) : bus.log2_factor;
    last_cnt_c  = CW'((8'd1 << lf) - 8'd1);
    group_end_c = accept_c && (cnt == last_cnt_c);
    sum_c       = acc + AW'($signed(bus.sample_in));
    avg_c       = sum_c >>> lf;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt              <= '0;
      acc              <= '0;
      lf               <= lf_sat_c;
      lm               <= bus.mode;
      new_sample_out_q <= 1'b0;
      sample_out_q     <= 16'h0000;
    end else begin
      new_sample_out_q <= 1'b0;
      if (group_end_c) begin
        sample_out_q     <= lm ? 16'(avg_c) : bus.sample_in;
        new_sample_out_q <= 1'b1;
        acc              <= '0;
        cnt              <= '0;
        lf               <= lf_sat_c;
        lm               <= bus.mode;
      end else if (accept_c) begin
        acc <= sum_c;
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign bus.new_sample_out = new_sample_out_q;
  assign bus.sample_out     = sample_out_q;
endmodule

// File: tb/tb_sample_decimator.sv
// Directed scoreboard bench: stimulus pushes expected (value, cycle) pairs,
// a negedge monitor pops and compares on every output strobe.
module tb_sample_decimator;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    logic [15:0] val;
    int          cyc;
  } exp_t;
  exp_t q[$];

  sample_decimator_if bus ();

  sample_decimator #(.MAX_LOG2(7)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every strobe must match the oldest expected entry, value and cycle.
  always @(negedge clk) begin
    if (bus.new_sample_out === 1'b1) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_strobe cycle=%0d sample_out=%0d", cyc, $signed(bus.sample_out));
      end else begin
        exp_t e;
        e = q.pop_front();
        if (bus.sample_out !== e.val || cyc != e.cyc) begin
          errors++;
          $display("FAIL strobe got value=%0d cycle=%0d expected value=%0d cycle=%0d",
                   $signed(bus.sample_out), cyc, $signed(e.val), e.cyc);
        end
      end
    end
  end

  task automatic check_idle_outputs(input string name);
    checks++;
    if (bus.new_sample_out !== 1'b0 || bus.sample_out !== 16'h0000) begin
      errors++;
      $display("FAIL %s got strobe=%b sample_out=%0d expected strobe=0 sample_out=0",
               name, bus.new_sample_out, $signed(bus.sample_out));
    end
  endtask

  // Reset for one cycle with the factor/mode to latch; optionally a strobe that must be dropped.
  task automatic do_reset(input logic [2:0] f, input logic m, input bit strobe);
    reset           = 1'b1;
    bus.log2_factor = f;
    bus.mode        = m;
    bus.new_sample_in = strobe;
    bus.sample_in   = 16'd1000;
    @(posedge clk); #1;
    reset             = 1'b0;
    bus.new_sample_in = 1'b0;
    check_idle_outputs("after_reset");
  endtask

  task automatic send(input logic [15:0] s, input bit has_exp, input logic [15:0] e);
    bus.new_sample_in = 1'b1;
    bus.sample_in     = s;
    @(posedge clk); #1;
    bus.new_sample_in = 1'b0;
    if (has_exp) q.push_back('{e, cyc});
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    bus.new_sample_in = 1'b0;
    bus.sample_in     = '0;
    bus.log2_factor   = '0;
    bus.mode          = 1'b1;
    bus.freeze        = 1'b0;
    #1;

    // Passthrough N=1, back-to-back.
    do_reset(3'd0, 1'b1, 1'b0);
    send(16'd5, 1, 16'd5);
    send(-16'sd7, 1, -16'sd7);
    send(16'd32767, 1, 16'd32767);
    idle(3);

    // Average N=4 with idle gaps: (100+200+300+400)/4 = 250.
    do_reset(3'd2, 1'b1, 1'b0);
    send(16'd100, 0, 0);
    send(16'd200, 0, 0); idle(3);
    send(16'd300, 0, 0); idle(2);
    send(16'd400, 1, 16'd250);
    idle(3);

    // Flooring: (-1 + -2) >>> 1 = -2.
    do_reset(3'd1, 1'b1, 1'b0);
    send(-16'sd1, 0, 0);
    send(-16'sd2, 1, -16'sd2);
    idle(2);

    // Subsample N=8 emits the last sample.
    do_reset(3'd3, 1'b0, 1'b0);
    for (int i = 1; i <= 8; i++) send(16'(i), (i == 8), 16'd8);
    idle(2);

    // Extremes at N=128.
    do_reset(3'd7, 1'b1, 1'b0);
    for (int i = 0; i < 128; i++) send(16'h8000, (i == 127), 16'h8000);
    idle(2);
    for (int i = 0; i < 128; i++) send(16'd32767, (i == 127), 16'd32767);
    idle(2);

    // Factor change mid-group only applies after the boundary.
    do_reset(3'd2, 1'b1, 1'b0);
    send(16'd10, 0, 0);
    send(16'd20, 0, 0);
    bus.log2_factor = 3'd0;
    send(16'd30, 0, 0);
    send(16'd40, 1, 16'd25);
    send(16'd7, 1, 16'd7);
    send(-16'sd3, 1, -16'sd3);
    idle(2);

    // Freeze preserves the partial group and drops strobes.
    do_reset(3'd1, 1'b1, 1'b0);
    send(16'd10, 0, 0);
    bus.freeze = 1'b1;
    for (int i = 0; i < 5; i++) send(16'd999, 0, 0);
    bus.freeze = 1'b0;
    send(16'd30, 1, 16'd20);
    idle(2);

    // Reset mid-group discards the partial group; the strobe during reset is dropped.
    do_reset(3'd2, 1'b1, 1'b0);
    send(16'd1, 0, 0);
    send(16'd2, 0, 0);
    send(16'd3, 0, 0);
    do_reset(3'd2, 1'b1, 1'b1);
    send(16'd4, 0, 0);
    send(16'd4, 0, 0);
    send(16'd4, 0, 0);
    send(16'd4, 1, 16'd4);
    idle(4);

    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL missing_strobes got outstanding=%0d expected 0", q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
